// File: rtl/vcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vcu_pkg
// Brief    : Shared opcodes, control-word layout and FSM states for the
//            vector sequenced control unit.
// Revision : 1.0 - initial release
// ============================================================================
package vcu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_MAC   = 3'b111;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;

  // mux[0] drives mux0 ... mux[3] drives mux3
  typedef struct packed {
    logic       we_a;
    logic       we_b;
    logic       we_mem;
    logic [3:0] mux;
  } ctrl_word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam ctrl_word_t CTRL_NONE = '0;

  function automatic ctrl_word_t mk_ctrl(input logic we_a, input logic we_b,
                                         input logic we_mem, input logic [3:0] mux);
    ctrl_word_t c;
    c.we_a   = we_a;
    c.we_b   = we_b;
    c.we_mem = we_mem;
    c.mux    = mux;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vcu_decode.sv
`default_nettype none
// ============================================================================
// Module   : vcu_decode
// Brief    : Combinational opcode to per-beat control word decoder.
// Revision : 1.0 - initial release
// ============================================================================
module vcu_decode
  import vcu_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] op_code_i,
  output ctrl_word_t      ctrl_o,
  output logic            illegal_o
);

  logic w_high_nz;

  generate
    if (OP_W > 3) begin : g_high_bits
      assign w_high_nz = |op_code_i[OP_W-1:3];
    end else begin : g_no_high_bits
      assign w_high_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    ctrl_o    = CTRL_NONE;
    illegal_o = 1'b0;
    case (op_code_i[2:0])
      OP_ADD, OP_SUB, OP_MUL: ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 4'b1100);
      OP_MAC:                 ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 4'b1000);
      OP_LOAD:                ctrl_o = mk_ctrl(1'b0, 1'b1, 1'b0, 4'b0010);
      OP_STORE:               ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b1, 4'b0011);
      default:                illegal_o = 1'b1;
    endcase
    // Any set bit beyond the decoded field makes the whole opcode undefined
    if (w_high_nz) begin
      ctrl_o    = CTRL_NONE;
      illegal_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vector_seq_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_seq_control_unit
// Brief    : Accepts one vector instruction and steps its elements one per
//            cycle, driving write enables and mux selects per beat.
//            Define VCU_CHAIN_EN for zero-bubble back-to-back instructions.
// Revision : 1.0 - initial release
// ============================================================================
module vector_seq_control_unit
  import vcu_pkg::*;
#(
  parameter  int OP_W  = 3,
  parameter  int VLEN  = 8,
  localparam int IDX_W = $clog2(VLEN),
  localparam int VL_W  = $clog2(VLEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OP_W-1:0]  op_code,
  input  logic [VL_W-1:0]  vl,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             illegal_op,
  output logic [IDX_W-1:0] elem_idx,
  output logic             we_a_reg,
  output logic             we_b_reg,
  output logic             we_mem,
  output logic             mux0,
  output logic             mux1,
  output logic             mux2,
  output logic             mux3
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VL_W-1:0]  vl_q, vl_d;
  ctrl_word_t       ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  ctrl_word_t       dec_ctrl;
  logic             dec_illegal;
  logic             exec_live;
  logic             last_beat;
  logic             accept;
  logic [VL_W-1:0]  vl_clamped;

  vcu_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .op_code_i (op_code),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  assign exec_live  = (state_q == EXEC) && !stall;
  assign last_beat  = exec_live && ((VL_W'(idx_q) + VL_W'(1)) == vl_q);
  assign vl_clamped = (vl > VL_W'(VLEN)) ? VL_W'(VLEN) : vl;

`ifdef VCU_CHAIN_EN
  assign instr_ready = (state_q == IDLE) || last_beat;
`else
  assign instr_ready = (state_q == IDLE);
`endif

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vl_d      = vl_q;
    ctrl_d    = ctrl_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;

    if (exec_live) begin
      if (last_beat) begin
        state_d = IDLE;
        idx_d   = '0;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // A chained accept overrides the retire path above but keeps its done pulse
    if (accept) begin
      idx_d = '0;
      if (dec_illegal || (vl == '0)) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        illegal_d = dec_illegal;
      end else begin
        state_d = EXEC;
        vl_d    = vl_clamped;
        ctrl_d  = dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vl_q      <= '0;
      ctrl_q    <= CTRL_NONE;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vl_q      <= vl_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy       = (state_q == EXEC);
  assign done       = done_q;
  assign illegal_op = illegal_q;
  assign elem_idx   = idx_q;

  // Write enables drop during a stall; mux selects hold so the datapath stays steady
  assign we_a_reg = exec_live && ctrl_q.we_a;
  assign we_b_reg = exec_live && ctrl_q.we_b;
  assign we_mem   = exec_live && ctrl_q.we_mem;
  assign mux0     = busy && ctrl_q.mux[0];
  assign mux1     = busy && ctrl_q.mux[1];
  assign mux2     = busy && ctrl_q.mux[2];
  assign mux3     = busy && ctrl_q.mux[3];

endmodule
`default_nettype wire

// File: tb/tb_vector_seq_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_seq_control_unit
// Brief    : Directed scoreboard bench for vector_seq_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_seq_control_unit;

  typedef struct packed {
    logic       beat;
    logic [2:0] idx;
    logic       we_a;
    logic       we_b;
    logic       we_mem;
    logic [3:0] mux;
    logic       done;
    logic       illegal;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] op_code;
  logic [3:0] vl;
  logic       stall;
  logic       busy;
  logic       done;
  logic       illegal_op;
  logic [2:0] elem_idx;
  logic       we_a_reg, we_b_reg, we_mem;
  logic       mux0, mux1, mux2, mux3;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  mon_en   = 0;
  ev_t exp_q[int];
  bit  stall_at[int];

  vector_seq_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op_code     (op_code),
    .vl          (vl),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .illegal_op  (illegal_op),
    .elem_idx    (elem_idx),
    .we_a_reg    (we_a_reg),
    .we_b_reg    (we_b_reg),
    .we_mem      (we_mem),
    .mux0        (mux0),
    .mux1        (mux1),
    .mux2        (mux2),
    .mux3        (mux3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_at.exists(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Hand-written decode table
  function automatic void model_word(input logic [2:0] op, output bit legal, output ev_t w);
    w     = '0;
    legal = 1'b1;
    case (op)
      3'b000, 3'b001, 3'b110: begin w.we_a = 1'b1; w.mux = 4'b1100; end
      3'b111:                 begin w.we_a = 1'b1; w.mux = 4'b1000; end
      3'b100:                 begin w.we_b = 1'b1; w.mux = 4'b0010; end
      3'b101:                 begin w.we_mem = 1'b1; w.mux = 4'b0011; end
      default:                legal = 1'b0;
    endcase
  endfunction

  function automatic void add_ev(input int c, input ev_t e);
    if (exp_q.exists(c)) exp_q[c] = exp_q[c] | e;
    else                 exp_q[c] = e;
  endfunction

  function automatic void push_model(input int t, input logic [2:0] op,
                                     input logic [3:0] v, input int abort_beats);
    ev_t w, e;
    bit  legal, aborted;
    int  n, c, k;
    model_word(op, legal, w);
    if (!legal || v == 4'd0) begin
      e = '0;
      e.done    = 1'b1;
      e.illegal = !legal;
      add_ev(t + 1, e);
      return;
    end
    n = (v > 4'd8) ? 8 : int'(v);
    c = t + 1;
    k = 0;
    aborted = 1'b0;
    while (k < n && !aborted) begin
      if (abort_beats >= 0 && k >= abort_beats) begin
        aborted = 1'b1;
      end else begin
        if (!stall_at.exists(c)) begin
          e      = w;
          e.beat = 1'b1;
          e.idx  = k[2:0];
          add_ev(c, e);
          k++;
        end
        c++;
      end
    end
    if (!aborted) begin
      e = '0;
      e.done = 1'b1;
      add_ev(c, e);
    end
  endfunction

  task automatic send(input logic [2:0] op, input logic [3:0] v, input int stall_mask,
                      input int abort_beats, output int t);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    op_code     = op;
    vl          = v;
    n = 0;
    while (!instr_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    for (int j = 0; j < 32; j++)
      if (stall_mask[j]) stall_at[t + j] = 1'b1;
    push_model(t, op, v, abort_beats);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    op_code     = 3'b011;
    vl          = 4'hF;
  endtask

  task automatic wait_to(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"}, instr_ready, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_ctrl"}, {we_a_reg, we_b_reg, we_mem, mux3, mux2, mux1, mux0}, 0);
  endtask

  // Scoreboard monitor: compares every cycle with DUT activity or a pending expectation
  initial begin
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act         = '0;
        act.beat    = busy && !stall;
        act.idx     = act.beat ? elem_idx : 3'd0;
        act.we_a    = we_a_reg;
        act.we_b    = we_b_reg;
        act.we_mem  = we_mem;
        act.mux     = act.beat ? {mux3, mux2, mux1, mux0} : 4'd0;
        act.done    = done;
        act.illegal = illegal_op;
        if ((act != '0) || exp_q.exists(cyc)) begin
          e = exp_q.exists(cyc) ? exp_q[cyc] : '0;
          if (exp_q.exists(cyc)) exp_q.delete(cyc);
          n_checks++;
          if (act !== e) begin
            n_fail++;
            $display("FAIL scoreboard cycle %0d: got beat=%0b idx=%0d we=%b mux=%b done=%0b ill=%0b expected beat=%0b idx=%0d we=%b mux=%b done=%0b ill=%0b",
                     cyc, act.beat, act.idx, {act.we_a, act.we_b, act.we_mem}, act.mux, act.done, act.illegal,
                     e.beat, e.idx, {e.we_a, e.we_b, e.we_mem}, e.mux, e.done, e.illegal);
          end
        end
      end
    end
  end

  initial begin
    int t, t2;
    rst         = 1'b1;
    instr_valid = 1'b0;
    op_code     = 3'b000;
    vl          = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_idx", elem_idx, 0);
    check("rst_ctrl", {we_a_reg, we_b_reg, we_mem, mux3, mux2, mux1, mux0}, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic add, 4 elements
    send(3'b000, 4'd4, 0, -1, t);
    wait_to(t + 4);
    check("t1_ready_last_beat", instr_ready, 0);
    wait_to(t + 5);
    check_idle("t1_after");

    // Store with a two-cycle stall on element 1
    send(3'b101, 4'd3, 32'b1100, -1, t);
    wait_to(t + 2);
    check("t2_stall_we_mem", we_mem, 0);
    check("t2_stall_mux", {mux1, mux0}, 2'b11);
    check("t2_stall_idx", elem_idx, 1);
    wait_to(t + 3);
    check("t2_stall2_idx", elem_idx, 1);
    check("t2_stall2_busy", busy, 1);
    wait_to(t + 6);
    check_idle("t2_after");

    // Illegal opcode retires immediately
    send(3'b011, 4'd5, 0, -1, t);
    wait_to(t + 1);
    check("t3_busy", busy, 0);

    // Zero length, then over-length clamped to 8
    send(3'b100, 4'd0, 0, -1, t);
    send(3'b100, 4'd15, 0, -1, t);
    wait_to(t + 8);
    check("t4_idx_last", elem_idx, 7);
    wait_to(t + 9);
    check_idle("t4_after");

    // Remaining opcodes; stall in the accept cycle must not matter
    send(3'b111, 4'd2, 0, -1, t);
    send(3'b110, 4'd1, 32'b1, -1, t);
    send(3'b001, 4'd3, 32'b10, -1, t);

    // Reset in the middle of an 8-element instruction
    send(3'b001, 4'd8, 0, 3, t);
    wait_to(t + 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_to(t + 4);
    check_idle("t5_after_rst");
    check("t5_idx", elem_idx, 0);
    send(3'b000, 4'd1, 0, -1, t);

    // Back-to-back instructions
    send(3'b000, 4'd2, 0, -1, t);
    send(3'b111, 4'd2, 0, -1, t2);
`ifdef VCU_CHAIN_EN
    check("t6_accept_gap", t2 - t, 2);
`else
    check("t6_accept_gap", t2 - t, 3);
`endif

    wait_to(cyc + 12);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
